// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART (bit-serial TX + RX) feeding a show-ahead receive FIFO.
// Define UART_PARITY_EN to insert/check a parity bit between the data bits and the stop bit.
module uart_fifo_core #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          xmitH,
    input  logic [DATA_BITS-1:0]          xmit_dataH,
    output logic                          xmit_busyH,
    output logic                          xmit_doneH,
    output logic                          uart_XMIT_dataH,
    input  logic                          uart_REC_dataH,
    input  logic                          rec_readH,
    output logic [DATA_BITS-1:0]          rec_dataH,
    output logic                          rec_readyH,
    output logic [$clog2(FIFO_DEPTH):0]   rec_countH,
    output logic                          rec_overflowH,
    output logic                          rec_frame_errH,
    output logic                          rec_parity_errH,
    output logic [2:0]                    dbg_tx_stateH,
    output logic [2:0]                    dbg_rx_stateH
);

`ifdef UART_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic          PAR_ODD  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Handshakes: xmitH is taken only while xmit_busyH is low, rec_readH pops only
    // while rec_readyH is high; a request outside those windows is dropped, never queued.

    state_t                tx_state_q;
    logic [CW-1:0]         tx_cnt_q;
    logic [BW-1:0]         tx_bit_q;
    logic [DATA_BITS-1:0]  tx_shift_q;
    logic                  tx_par_q;
    logic                  tx_line_q;
    logic                  tx_busy_q;
    logic                  tx_done_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_line_q  <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            if (tx_state_q != ST_IDLE) begin
                tx_cnt_q <= (tx_cnt_q == CNT_LAST) ? '0 : tx_cnt_q + 1'b1;
            end
            case (tx_state_q)
                ST_IDLE: begin
                    if (xmitH) begin
                        tx_state_q <= ST_START;
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_shift_q <= xmit_dataH;
                        tx_par_q   <= (^xmit_dataH) ^ PAR_ODD;
                        tx_line_q  <= 1'b0;
                        tx_busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_state_q <= ST_DATA;
                        tx_line_q  <= tx_shift_q[0];
                    end
                end
                ST_DATA: begin
                    if (tx_cnt_q == CNT_LAST) begin
                        if (tx_bit_q == BIT_LAST) begin
                            tx_bit_q <= '0;
                            if (PARITY_EN) begin
                                tx_state_q <= ST_PARITY;
                                tx_line_q  <= tx_par_q;
                            end else begin
                                tx_state_q <= ST_STOP;
                                tx_line_q  <= 1'b1;
                            end
                        end else begin
                            tx_bit_q   <= tx_bit_q + 1'b1;
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_line_q  <= tx_shift_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_state_q <= ST_STOP;
                        tx_line_q  <= 1'b1;
                    end
                end
                ST_STOP: begin
                    // done is registered, so raise it one cycle early to land on the last stop cycle
                    if (tx_cnt_q == CNT_DONE) tx_done_q <= 1'b1;
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_state_q <= ST_IDLE;
                        tx_busy_q  <= 1'b0;
                    end
                end
                default: tx_state_q <= ST_IDLE;
            endcase
        end
    end

    logic                  sync1_q;
    logic                  sync2_q;
    logic                  rx_prev_q;
    state_t                rx_state_q;
    logic [CW-1:0]         rx_cnt_q;
    logic [BW-1:0]         rx_bit_q;
    logic [DATA_BITS-1:0]  rx_shift_q;
    logic                  rx_perr_q;
    logic                  rx_ferr_pulse_q;
    logic                  rx_perr_pulse_q;
    logic                  rx_push;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q         <= 1'b1;
            sync2_q         <= 1'b1;
            rx_prev_q       <= 1'b1;
            rx_state_q      <= ST_IDLE;
            rx_cnt_q        <= '0;
            rx_bit_q        <= '0;
            rx_shift_q      <= '0;
            rx_perr_q       <= 1'b0;
            rx_ferr_pulse_q <= 1'b0;
            rx_perr_pulse_q <= 1'b0;
        end else begin
            sync1_q         <= uart_REC_dataH;
            sync2_q         <= sync1_q;
            rx_prev_q       <= sync2_q;
            rx_ferr_pulse_q <= 1'b0;
            rx_perr_pulse_q <= 1'b0;
            if (rx_state_q != ST_IDLE) begin
                rx_cnt_q <= (rx_cnt_q == CNT_LAST) ? '0 : rx_cnt_q + 1'b1;
            end
            case (rx_state_q)
                ST_IDLE: begin
                    // Edge-triggered arming: after a frame error the line must return high first
                    if (rx_prev_q && !sync2_q) begin
                        rx_state_q <= ST_START;
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_perr_q  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (rx_cnt_q == CNT_HALF) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= sync2_q ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt_q == CNT_LAST) begin
                        rx_shift_q <= {sync2_q, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_bit_q == BIT_LAST) begin
                            rx_bit_q   <= '0;
                            rx_state_q <= PARITY_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (rx_cnt_q == CNT_LAST) begin
                        rx_perr_q  <= sync2_q != ((^rx_shift_q) ^ PAR_ODD);
                        rx_state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (rx_cnt_q == CNT_LAST) begin
                        rx_state_q <= ST_IDLE;
                        if (!sync2_q)       rx_ferr_pulse_q <= 1'b1;
                        else if (rx_perr_q) rx_perr_pulse_q <= 1'b1;
                    end
                end
                default: rx_state_q <= ST_IDLE;
            endcase
        end
    end

    assign rx_push = (rx_state_q == ST_STOP) && (rx_cnt_q == CNT_LAST) && sync2_q && !rx_perr_q;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [AW:0]          count_q;
    logic                 ovf_q;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;
    logic                 push;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        pop        = rec_readH && !fifo_empty;
        push       = rx_push && (!fifo_full || pop);
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_shift_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ovf_q <= rx_push && fifo_full && !pop;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign xmit_busyH      = tx_busy_q;
    assign xmit_doneH      = tx_done_q;
    assign uart_XMIT_dataH = tx_line_q;
    assign rec_dataH       = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign rec_readyH      = !fifo_empty;
    assign rec_countH      = count_q;
    assign rec_overflowH   = ovf_q;
    assign rec_frame_errH  = rx_ferr_pulse_q;
    assign rec_parity_errH = PARITY_EN ? rx_perr_pulse_q : 1'b0;
    assign dbg_tx_stateH   = tx_state_q;
    assign dbg_rx_stateH   = rx_state_q;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: loopback, FIFO overflow, RX glitch/frame/parity errors, resets.
// Builds with or without UART_PARITY_EN; expectations follow the macro.
module tb_uart_fifo_core;
    localparam int DATA_BITS    = 8;
    localparam int CLKS_PER_BIT = 16;
    localparam int FIFO_DEPTH   = 8;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 3;
`else
    localparam int FRAME_BITS = DATA_BITS + 2;
`endif

    logic                  sys_clk = 1'b0;
    logic                  sys_rst = 1'b1;
    logic                  xmitH = 1'b0;
    logic [DATA_BITS-1:0]  xmit_dataH = '0;
    logic                  xmit_busyH;
    logic                  xmit_doneH;
    logic                  uart_XMIT_dataH;
    logic                  uart_REC_dataH;
    logic                  rec_readH = 1'b0;
    logic [DATA_BITS-1:0]  rec_dataH;
    logic                  rec_readyH;
    logic [3:0]            rec_countH;
    logic                  rec_overflowH;
    logic                  rec_frame_errH;
    logic                  rec_parity_errH;
    logic [2:0]            dbg_tx_stateH;
    logic [2:0]            dbg_rx_stateH;

    logic loop_en = 1'b0;
    logic drv_rx  = 1'b1;
    assign uart_REC_dataH = loop_en ? uart_XMIT_dataH : drv_rx;

    int vectors = 0;
    int miscompares = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;
    int ovf_cnt = 0;

    uart_fifo_core #(
        .DATA_BITS(DATA_BITS), .CLKS_PER_BIT(CLKS_PER_BIT),
        .FIFO_DEPTH(FIFO_DEPTH), .PARITY_ODD(0)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .xmitH(xmitH), .xmit_dataH(xmit_dataH), .xmit_busyH(xmit_busyH), .xmit_doneH(xmit_doneH),
        .uart_XMIT_dataH(uart_XMIT_dataH), .uart_REC_dataH(uart_REC_dataH),
        .rec_readH(rec_readH), .rec_dataH(rec_dataH), .rec_readyH(rec_readyH),
        .rec_countH(rec_countH), .rec_overflowH(rec_overflowH),
        .rec_frame_errH(rec_frame_errH), .rec_parity_errH(rec_parity_errH),
        .dbg_tx_stateH(dbg_tx_stateH), .dbg_rx_stateH(dbg_rx_stateH)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (rec_frame_errH)  fe_cnt++;
        if (rec_parity_errH) pe_cnt++;
        if (rec_overflowH)   ovf_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pop_one();
        rec_readH = 1'b1;
        tick(1);
        rec_readH = 1'b0;
    endtask

    // Waits for the transmitter to go idle, launches one frame and returns on xmit_doneH.
    task automatic send_byte(input logic [DATA_BITS-1:0] d);
        int k;
        k = 0;
        while (xmit_busyH && k < 1000) begin tick(1); k++; end
        xmit_dataH = d;
        xmitH = 1'b1;
        tick(1);
        xmitH = 1'b0;
        k = 1;
        while (!xmit_doneH && k < 1000) begin tick(1); k++; end
        vectors++;
        if (!xmit_doneH) begin
            miscompares++;
            $display("FAIL send_timeout: xmit_doneH=%0b after %0d cycles, expected 1", xmit_doneH, k);
        end
    endtask

    task automatic inject_frame(input logic [DATA_BITS-1:0] d, input logic par, input logic stop);
        drv_rx = 1'b0;
        tick(CLKS_PER_BIT);
        for (int i = 0; i < DATA_BITS; i++) begin
            drv_rx = d[i];
            tick(CLKS_PER_BIT);
        end
`ifdef UART_PARITY_EN
        drv_rx = par;
        tick(CLKS_PER_BIT);
`endif
        drv_rx = stop;
        tick(CLKS_PER_BIT);
        drv_rx = 1'b1;
        tick(2 * CLKS_PER_BIT);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        tick(3);
        vectors++; if (uart_XMIT_dataH !== 1'b1) begin miscompares++; $display("FAIL rst_line: got %b expected 1", uart_XMIT_dataH); end
        vectors++; if (xmit_busyH !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", xmit_busyH); end
        vectors++; if (xmit_doneH !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b expected 0", xmit_doneH); end
        vectors++; if (rec_countH !== 4'd0) begin miscompares++; $display("FAIL rst_count: got %0d expected 0", rec_countH); end
        vectors++; if (rec_readyH !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b expected 0", rec_readyH); end
        vectors++; if (rec_dataH !== 8'h00) begin miscompares++; $display("FAIL rst_data: got %h expected 00", rec_dataH); end
        vectors++; if ({rec_overflowH, rec_frame_errH, rec_parity_errH} !== 3'b000) begin miscompares++; $display("FAIL rst_pulses: got %b expected 000", {rec_overflowH, rec_frame_errH, rec_parity_errH}); end
        vectors++; if ({dbg_tx_stateH, dbg_rx_stateH} !== 6'd0) begin miscompares++; $display("FAIL rst_states: got %h expected 0", {dbg_tx_stateH, dbg_rx_stateH}); end
        sys_rst = 1'b0;
        tick(2);
    endtask

    task automatic test_loopback();
        int cyc;
        loop_en = 1'b1;
        xmit_dataH = 8'hA5;
        xmitH = 1'b1;
        tick(1);
        xmitH = 1'b0;
        vectors++; if (xmit_busyH !== 1'b1) begin miscompares++; $display("FAIL lb_busy_rise: got %b expected 1", xmit_busyH); end
        vectors++; if (uart_XMIT_dataH !== 1'b0) begin miscompares++; $display("FAIL lb_start_bit: got %b expected 0", uart_XMIT_dataH); end
        cyc = 1;
        while (!xmit_doneH && cyc < 1000) begin
            // a request while busy must be ignored
            if (cyc == 50) begin xmitH = 1'b1; xmit_dataH = 8'hFF; end
            if (cyc == 51) xmitH = 1'b0;
            tick(1);
            cyc++;
        end
        vectors++; if (cyc !== FRAME_BITS * CLKS_PER_BIT) begin miscompares++; $display("FAIL lb_done_latency: got %0d expected %0d", cyc, FRAME_BITS * CLKS_PER_BIT); end
        tick(1);
        vectors++; if (xmit_doneH !== 1'b0) begin miscompares++; $display("FAIL lb_done_width: got %b expected 0", xmit_doneH); end
        vectors++; if (xmit_busyH !== 1'b0) begin miscompares++; $display("FAIL lb_busy_fall: got %b expected 0", xmit_busyH); end
        tick(20);
        vectors++; if (rec_readyH !== 1'b1) begin miscompares++; $display("FAIL lb_ready: got %b expected 1", rec_readyH); end
        vectors++; if (rec_dataH !== 8'hA5) begin miscompares++; $display("FAIL lb_data: got %h expected a5", rec_dataH); end
        vectors++; if (rec_countH !== 4'd1) begin miscompares++; $display("FAIL lb_count: got %0d expected 1", rec_countH); end
        pop_one();
        vectors++; if (rec_countH !== 4'd0) begin miscompares++; $display("FAIL lb_count_after_pop: got %0d expected 0", rec_countH); end
        vectors++; if (rec_dataH !== 8'h00) begin miscompares++; $display("FAIL lb_data_empty: got %h expected 00", rec_dataH); end
    endtask

    task automatic test_overflow();
        logic [DATA_BITS-1:0] exp_q[$];
        logic [DATA_BITS-1:0] exp;
        int ovf0;
        loop_en = 1'b1;
        ovf0 = ovf_cnt;
        for (int i = 0; i < 8; i++) begin
            send_byte(DATA_BITS'(i));
            exp_q.push_back(DATA_BITS'(i));
        end
        tick(3);
        vectors++; if (ovf_cnt - ovf0 !== 0) begin miscompares++; $display("FAIL ovf_early: got %0d pulses expected 0", ovf_cnt - ovf0); end
        vectors++; if (rec_countH !== 4'd8) begin miscompares++; $display("FAIL ovf_full_count: got %0d expected 8", rec_countH); end
        send_byte(8'h08);
        tick(3);
        vectors++; if (ovf_cnt - ovf0 !== 1) begin miscompares++; $display("FAIL ovf_pulse: got %0d pulses expected 1", ovf_cnt - ovf0); end
        vectors++; if (rec_countH !== 4'd8) begin miscompares++; $display("FAIL ovf_count_kept: got %0d expected 8", rec_countH); end
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            vectors++; if (rec_dataH !== exp) begin miscompares++; $display("FAIL ovf_read_order: got %h expected %h", rec_dataH, exp); end
            pop_one();
        end
        vectors++; if (rec_readyH !== 1'b0) begin miscompares++; $display("FAIL ovf_drained: got ready=%b expected 0", rec_readyH); end
        // pop while empty is ignored
        pop_one();
        vectors++; if (rec_countH !== 4'd0) begin miscompares++; $display("FAIL ovf_pop_empty: got %0d expected 0", rec_countH); end
    endtask

    task automatic test_glitch();
        int fe0, pe0;
        loop_en = 1'b0;
        drv_rx = 1'b1;
        fe0 = fe_cnt;
        pe0 = pe_cnt;
        tick(4);
        drv_rx = 1'b0;
        tick(4);
        drv_rx = 1'b1;
        tick(40);
        vectors++; if (rec_countH !== 4'd0) begin miscompares++; $display("FAIL glitch_count: got %0d expected 0", rec_countH); end
        vectors++; if (fe_cnt - fe0 !== 0) begin miscompares++; $display("FAIL glitch_frame_err: got %0d expected 0", fe_cnt - fe0); end
        vectors++; if (pe_cnt - pe0 !== 0) begin miscompares++; $display("FAIL glitch_parity_err: got %0d expected 0", pe_cnt - pe0); end
        vectors++; if (dbg_rx_stateH !== 3'd0) begin miscompares++; $display("FAIL glitch_rx_idle: got %0d expected 0", dbg_rx_stateH); end
    endtask

    task automatic test_frame_err();
        int fe0;
        loop_en = 1'b0;
        fe0 = fe_cnt;
        inject_frame(8'h3C, 1'b0, 1'b0);   // 8'h3C has four ones: even parity bit 0
        vectors++; if (fe_cnt - fe0 !== 1) begin miscompares++; $display("FAIL ferr_pulse: got %0d expected 1", fe_cnt - fe0); end
        vectors++; if (rec_countH !== 4'd0) begin miscompares++; $display("FAIL ferr_count: got %0d expected 0", rec_countH); end
        inject_frame(8'h11, 1'b0, 1'b1);   // 8'h11 has two ones: even parity bit 0
        vectors++; if (rec_countH !== 4'd1) begin miscompares++; $display("FAIL ferr_next_count: got %0d expected 1", rec_countH); end
        vectors++; if (rec_dataH !== 8'h11) begin miscompares++; $display("FAIL ferr_next_data: got %h expected 11", rec_dataH); end
        vectors++; if (fe_cnt - fe0 !== 1) begin miscompares++; $display("FAIL ferr_no_extra: got %0d expected 1", fe_cnt - fe0); end
        pop_one();
    endtask

    task automatic test_parity();
        int cyc, pe0;
        loop_en = 1'b1;
        xmit_dataH = 8'h07;
        xmitH = 1'b1;
        tick(1);
        xmitH = 1'b0;
        cyc = 1;
        while (cyc < 9 * CLKS_PER_BIT + CLKS_PER_BIT / 2) begin tick(1); cyc++; end
        // bit-time 9 is the parity bit (three ones -> 1) when enabled, else the stop bit (1)
        vectors++; if (uart_XMIT_dataH !== 1'b1) begin miscompares++; $display("FAIL par_tx_bit9: got %b expected 1", uart_XMIT_dataH); end
        while (!xmit_doneH && cyc < 1000) begin tick(1); cyc++; end
        tick(2);
        vectors++; if (rec_dataH !== 8'h07) begin miscompares++; $display("FAIL par_loop_data: got %h expected 07", rec_dataH); end
        pop_one();
        loop_en = 1'b0;
        pe0 = pe_cnt;
        inject_frame(8'h07, 1'b0, 1'b1);
`ifdef UART_PARITY_EN
        vectors++; if (pe_cnt - pe0 !== 1) begin miscompares++; $display("FAIL par_err_pulse: got %0d expected 1", pe_cnt - pe0); end
        vectors++; if (rec_countH !== 4'd0) begin miscompares++; $display("FAIL par_err_drop: got %0d expected 0", rec_countH); end
`else
        vectors++; if (pe_cnt - pe0 !== 0) begin miscompares++; $display("FAIL par_err_tied: got %0d expected 0", pe_cnt - pe0); end
        vectors++; if (rec_countH !== 4'd1) begin miscompares++; $display("FAIL par_plain_count: got %0d expected 1", rec_countH); end
        pop_one();
`endif
    endtask

    task automatic test_back_to_back();
        int cyc;
        loop_en = 1'b1;
        xmit_dataH = 8'h33;
        xmitH = 1'b1;
        cyc = 0;
        while (!xmit_doneH && cyc < 1000) begin tick(1); cyc++; end
        xmit_dataH = 8'h44;
        tick(1);
        vectors++; if ({xmit_busyH, uart_XMIT_dataH} !== 2'b01) begin miscompares++; $display("FAIL b2b_idle_gap: got busy/line=%b expected 01", {xmit_busyH, uart_XMIT_dataH}); end
        tick(1);
        vectors++; if ({xmit_busyH, uart_XMIT_dataH} !== 2'b10) begin miscompares++; $display("FAIL b2b_restart: got busy/line=%b expected 10", {xmit_busyH, uart_XMIT_dataH}); end
        xmitH = 1'b0;
        cyc = 0;
        while (!xmit_doneH && cyc < 1000) begin tick(1); cyc++; end
        tick(3);
        vectors++; if (rec_countH !== 4'd2) begin miscompares++; $display("FAIL b2b_count: got %0d expected 2", rec_countH); end
        vectors++; if (rec_dataH !== 8'h33) begin miscompares++; $display("FAIL b2b_first: got %h expected 33", rec_dataH); end
        pop_one();
        vectors++; if (rec_dataH !== 8'h44) begin miscompares++; $display("FAIL b2b_second: got %h expected 44", rec_dataH); end
        pop_one();
    endtask

    task automatic test_reset_mid();
        int fe0;
        loop_en = 1'b1;
        send_byte(8'h42);
        tick(3);
        vectors++; if (rec_countH !== 4'd1) begin miscompares++; $display("FAIL rmid_pre_count: got %0d expected 1", rec_countH); end
        xmit_dataH = 8'h81;
        xmitH = 1'b1;
        tick(1);
        xmitH = 1'b0;
        tick(60);
        fe0 = fe_cnt;
        sys_rst = 1'b1;
        tick(1);
        sys_rst = 1'b0;
        vectors++; if (uart_XMIT_dataH !== 1'b1) begin miscompares++; $display("FAIL rmid_line: got %b expected 1", uart_XMIT_dataH); end
        vectors++; if (xmit_busyH !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b expected 0", xmit_busyH); end
        vectors++; if (rec_countH !== 4'd0) begin miscompares++; $display("FAIL rmid_count: got %0d expected 0", rec_countH); end
        vectors++; if (rec_dataH !== 8'h00) begin miscompares++; $display("FAIL rmid_data: got %h expected 00", rec_dataH); end
        vectors++; if ({dbg_tx_stateH, dbg_rx_stateH} !== 6'd0) begin miscompares++; $display("FAIL rmid_states: got %h expected 0", {dbg_tx_stateH, dbg_rx_stateH}); end
        tick(200);
        vectors++; if (rec_countH !== 4'd0) begin miscompares++; $display("FAIL rmid_no_partial: got %0d expected 0", rec_countH); end
        vectors++; if (fe_cnt - fe0 !== 0) begin miscompares++; $display("FAIL rmid_no_ferr: got %0d expected 0", fe_cnt - fe0); end
        send_byte(8'h5A);
        tick(3);
        vectors++; if (rec_countH !== 4'd1) begin miscompares++; $display("FAIL rmid_after_count: got %0d expected 1", rec_countH); end
        vectors++; if (rec_dataH !== 8'h5A) begin miscompares++; $display("FAIL rmid_after_data: got %h expected 5a", rec_dataH); end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_overflow();
        test_glitch();
        test_frame_err();
        test_parity();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
